// File: rtl/ula_pkg.sv
// Shared definitions for the sequential ALU: op codes, FSM states and flag bit positions.
package ula_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_SAR = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_DIV = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_e;

    // Bit positions inside ULA_flags = {Z,N,C,V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/ula_comb.sv
// Single-cycle ALU operations (add/sub/logic/shifts); reserved and iterative codes yield zero.
module ula_comb
    import ula_pkg::*;
#(
    parameter int TAM = 16
) (
    input  logic [TAM-1:0] a_i,
    input  logic [TAM-1:0] b_i,
    input  logic [3:0]     op_i,
    output logic [TAM-1:0] res_o,
    output logic           c_o,
    output logic           v_o
);

    localparam int SHW = $clog2(TAM);

    logic [SHW-1:0]      sh;
    logic [TAM:0]        wide;
    logic signed [TAM:0] swide;

    assign sh = b_i[SHW-1:0];

    always_comb begin
        res_o = '0;
        c_o   = 1'b0;
        v_o   = 1'b0;
        wide  = '0;
        swide = '0;
        case (op_i)
            OP_ADD: begin
                wide  = {1'b0, a_i} + {1'b0, b_i};
                res_o = wide[TAM-1:0];
                c_o   = wide[TAM];
                v_o   = (a_i[TAM-1] == b_i[TAM-1]) && (res_o[TAM-1] != a_i[TAM-1]);
            end
            OP_SUB: begin
                wide  = {1'b0, a_i} - {1'b0, b_i};
                res_o = wide[TAM-1:0];
                c_o   = wide[TAM];
                v_o   = (a_i[TAM-1] != b_i[TAM-1]) && (res_o[TAM-1] != a_i[TAM-1]);
            end
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            OP_NOT: res_o = ~a_i;
            // An extra guard bit on the shifted-out side captures the last bit lost.
            OP_SHL: begin
                wide  = {1'b0, a_i} << sh;
                res_o = wide[TAM-1:0];
                c_o   = wide[TAM];
            end
            OP_SHR: begin
                wide  = {a_i, 1'b0} >> sh;
                res_o = wide[TAM:1];
                c_o   = wide[0];
            end
            OP_SAR: begin
                swide = $signed({a_i, 1'b0}) >>> sh;
                res_o = swide[TAM:1];
                c_o   = swide[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ula_seq.sv
// Sequential ALU: single-cycle ops via ula_comb, iterative unsigned MUL/DIV over TAM cycles
// sharing one 2*TAM-bit shift register; all results and flags are registered.
module ula_seq
    import ula_pkg::*;
#(
    parameter int TAM = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [TAM-1:0] A_ULA,
    input  logic [TAM-1:0] B_ULA,
    input  logic [3:0]     ULA_op,
    input  logic           ULA_start,
    input  logic           ULA_flush,
    output logic [TAM-1:0] ULA_out,
    output logic [TAM-1:0] ULA_out_hi,
    output logic [3:0]     ULA_flags,
    output logic           ULA_busy,
    output logic           ULA_done
);

    localparam int              SHW      = $clog2(TAM);
    localparam int              CW       = SHW + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TAM - 1);

    state_e             state_q, state_d;
    logic [2*TAM-1:0]   sr_q, sr_d, mul_next, div_next;
    logic [TAM-1:0]     b_q, b_d;
    logic [TAM-1:0]     out_q, out_d, hi_q, hi_d;
    logic [3:0]         flags_q, flags_d;
    logic               done_q, done_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [TAM-1:0]     comb_res;
    logic               comb_c, comb_v;
    logic [TAM:0]       mul_sum, div_diff;
    logic               b_zero, iter_op, last_iter;
    logic               res_c, res_v;

    ula_comb #(.TAM(TAM)) u_comb (
        .a_i   (A_ULA),
        .b_i   (B_ULA),
        .op_i  (ULA_op),
        .res_o (comb_res),
        .c_o   (comb_c),
        .v_o   (comb_v)
    );

    assign b_zero    = (B_ULA == '0);
    assign iter_op   = (ULA_op == OP_MUL) || ((ULA_op == OP_DIV) && !b_zero);
    assign last_iter = (cnt_q == CNT_LAST);

    // Shift-add: low half holds the remaining multiplier bits, high half accumulates.
    assign mul_sum  = {1'b0, sr_q[2*TAM-1:TAM]} + {1'b0, b_q};
    assign mul_next = sr_q[0] ? {mul_sum, sr_q[TAM-1:1]} : {1'b0, sr_q[2*TAM-1:1]};

    // Restoring divide: {remainder, quotient}; a negative trial difference keeps the shifted value.
    assign div_diff = sr_q[2*TAM-1:TAM-1] - {1'b0, b_q};
    assign div_next = div_diff[TAM] ? {sr_q[2*TAM-2:0], 1'b0}
                                    : {div_diff[TAM-1:0], sr_q[TAM-2:0], 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (ULA_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ULA_start && (ULA_op == OP_MUL)) begin
                        state_d = ST_MUL;
                    end else if (ULA_start && (ULA_op == OP_DIV) && !b_zero) begin
                        state_d = ST_DIV;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (last_iter) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ULA_busy = (state_q != ST_IDLE);
    end

    always_comb begin
        sr_d    = sr_q;
        b_d     = b_q;
        out_d   = out_q;
        hi_d    = hi_q;
        flags_d = flags_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        if (ULA_flush) begin
            cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ULA_start) begin
                        if (iter_op) begin
                            sr_d  = {{TAM{1'b0}}, A_ULA};
                            b_d   = B_ULA;
                            cnt_d = '0;
                        end else if (ULA_op == OP_DIV) begin
                            out_d  = '1;
                            hi_d   = A_ULA;
                            res_v  = 1'b1;
                            done_d = 1'b1;
                        end else begin
                            out_d  = comb_res;
                            hi_d   = '0;
                            res_c  = comb_c;
                            res_v  = comb_v;
                            done_d = 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    sr_d  = mul_next;
                    cnt_d = cnt_q + CW'(1);
                    if (last_iter) begin
                        out_d  = mul_next[TAM-1:0];
                        hi_d   = mul_next[2*TAM-1:TAM];
                        res_c  = (mul_next[2*TAM-1:TAM] != '0);
                        done_d = 1'b1;
                        cnt_d  = '0;
                    end
                end
                ST_DIV: begin
                    sr_d  = div_next;
                    cnt_d = cnt_q + CW'(1);
                    if (last_iter) begin
                        out_d  = div_next[TAM-1:0];
                        hi_d   = div_next[2*TAM-1:TAM];
                        done_d = 1'b1;
                        cnt_d  = '0;
                    end
                end
                default: cnt_d = '0;
            endcase
        end
        if (done_d) begin
            flags_d[FLAG_Z] = (out_d == '0);
            flags_d[FLAG_N] = out_d[TAM-1];
            flags_d[FLAG_C] = res_c;
            flags_d[FLAG_V] = res_v;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q    <= '0;
            b_q     <= '0;
            out_q   <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            sr_q    <= sr_d;
            b_q     <= b_d;
            out_q   <= out_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign ULA_out    = out_q;
    assign ULA_out_hi = hi_q;
    assign ULA_flags  = flags_q;
    assign ULA_done   = done_q;

endmodule

// File: doc/ula_seq.md
ULA_SEQ -- requirements
Module: ula_seq

Interface
REQ-001 SHALL have parameter: TAM, 16, datapath width in bits; TAM power of two, >= 8.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- A_ULA  in  TAM  operand A, from the operand-select stage.
- B_ULA  in  TAM  operand B, from the operand-select stage.
- ULA_op  in  4  operation code.
- ULA_start  in  1  request; sampled only in IDLE.
- ULA_flush  in  1  abort the current operation.
- ULA_out  out  TAM  result low: sum, logic, shift, product low, or quotient.
- ULA_out_hi  out  TAM  product high or remainder; 0 for other ops.
- ULA_flags  out  4  {Z,N,C,V}, registered.
- ULA_busy  out  1  high in MUL or DIV state.
- ULA_done  out  1  one-cycle pulse when outputs are updated.
REQ-003 SHALL use one clock with synchronous active-high reset, as decided.

Function
REQ-004 Op codes SHALL be:
- 0 ADD
- 1 SUB (A-B)
- 2 AND
- 3 OR
- 4 XOR
- 5 NOT A
- 6 SHL
- 7 SHR
- 8 SAR
- 9 MUL, unsigned
- 10 DIV, unsigned
- 11-15 reserved
REQ-005 The state machine SHALL have states IDLE, MUL and DIV.
REQ-006 In IDLE, start with ops 0-8 or 11-15: outputs registered at that edge; ULA_done high the next cycle; state stays IDLE; latency 1.
REQ-007 In IDLE, start with op 9 or 10 (divisor nonzero):
- operands latched; go to MUL or DIV.
- one shift-add or restoring-subtract iteration per cycle, for exactly TAM cycles.
- outputs and done update on the TAM-th iteration edge; then return to IDLE.
- total latency TAM+1 edges (17 at TAM=16).
REQ-008 DIV with B_ULA==0: latency 1, ULA_out = all ones, ULA_out_hi = A, V=1; no DIV state entered.
REQ-009 ULA_start while busy SHALL be ignored; operand and op changes while busy SHALL NOT affect the result.
REQ-010 Start in the cycle ULA_done is high SHALL be accepted (back-to-back issue).
REQ-011 Between done pulses, ULA_out, ULA_out_hi and ULA_flags SHALL hold their values.
REQ-012 Flag rules, for every op:
- Z = (ULA_out==0).
- N = ULA_out[TAM-1].
REQ-013 C flag:
- ADD: carry out.
- SUB: borrow (A<B unsigned).
- shifts: last bit shifted out; 0 when amount is 0.
- MUL: (ULA_out_hi != 0).
- all other ops: 0.
REQ-014 V flag:
- ADD/SUB: signed overflow.
- DIV: divide-by-zero.
- all other ops: 0.
REQ-015 Shift amount SHALL be B_ULA[log2(TAM)-1:0]; SAR SHALL replicate the MSB.
REQ-016 Arithmetic SHALL wrap modulo 2^TAM; the MUL product SHALL be 2*TAM bits, as {ULA_out_hi,ULA_out}.
REQ-017 Reserved ops SHALL give ULA_out=0, ULA_out_hi=0, flags {1,0,0,0}, with done after 1 cycle.
REQ-018 ULA_flush: next state IDLE; no done; outputs unchanged.
- flush has priority over start in the same cycle.
- flush in IDLE is a no-op.

Reset
REQ-019 While rst is high at an edge:
- state IDLE.
- ULA_out, ULA_out_hi, ULA_flags = 0.
- ULA_busy = 0, ULA_done = 0.
- iteration counter = 0.
REQ-020 Reset mid-MUL/DIV SHALL abort without a done pulse; rst has priority over flush and start.

Structure
REQ-021 Package ula_pkg SHALL hold:
- op-code constants.
- state encoding.
- flag bit indices (Z=3, N=2, C=1, V=0).
REQ-022 Sub-module ula_comb SHALL implement ops 0-8 and 11-15 combinationally (result, C, V); ula_seq registers its outputs.
REQ-023 The iteration counter SHALL be log2(TAM)+1 bits; MUL and DIV SHALL share one 2*TAM-bit shift register.

Verification
REQ-024 ADD: A=16'h7FFF, B=16'h0001 -> after 1 cycle ULA_out=16'h8000, flags {0,1,0,1}, done 1 cycle.
REQ-025 SUB: A=3, B=5 -> ULA_out=16'hFFFE, flags {0,1,1,0}.
REQ-026 MUL: A=16'hFFFF, B=16'hFFFF -> busy for 16 cycles, done at edge 17, {hi,lo}=32'hFFFE0001, C=1; a start pulse during busy is ignored.
REQ-027 DIV:
- A=100, B=7 -> quotient 14, remainder 2 at edge 17.
- B=0 -> 16'hFFFF / A, V=1, latency 1.
REQ-028 Abort and reset:
- flush at cycle 5 of MUL -> no done, IDLE next cycle, outputs keep prior values.
- rst at cycle 8 of DIV -> all outputs 0.
REQ-029 Back-to-back: SHL (A=16'h8001, B=1) then restart in the done cycle with SAR (A=16'h8000, B=15).
- SHL: 16'h0002, C=1.
- SAR: 16'hFFFF, C=0.
